// File: rtl/cmos_cap_pkg.sv
// Shared types, defaults and helpers for the CMOS DVP capture front-end.
// The IMG_ROW/IMG_COL defaults here are also used by img_proc.
package cmos_cap_pkg;

  typedef enum logic [1:0] {
    ST_SKIP       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2,
    ST_DONE       = 2'd3
  } cap_state_e;

  localparam bit BYTE_HI_FIRST = 1'b1;
  localparam int IMG_ROW_DEF   = 8;
  localparam int IMG_COL_DEF   = 512;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // The first byte of a sensor pair is placed according to BYTE_HI_FIRST.
  function automatic logic [15:0] pack_pixel(input logic [7:0] first_b, input logic [7:0] second_b);
    if (BYTE_HI_FIRST) begin
      return {first_b, second_b};
    end else begin
      return {second_b, first_b};
    end
  endfunction

endpackage

// File: rtl/cmos_capture_16b_sync_edge.sv
// Input register stage for the DVP pins: one capture flop per pin, a second
// delay stage on vsync/href, and the frame/line edge strobes derived from them.
module cmos_sync_edge #(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] d_i,
  output logic       vs_start,
  output logic       vs_act,
  output logic       href_r,
  output logic       href_fall,
  output logic [7:0] d_r
);

  logic       vs_d, vs_q, vs_dly_d, vs_dly_q;
  logic       href_d, href_q, href_dly_d, href_dly_q;
  logic [7:0] d_d, d_q;

  // next-state for the capture and delay stages; vsync normalised to active-high
  always_comb begin
    vs_d       = (vsync_i == VSYNC_POL);
    href_d     = href_i;
    d_d        = d_i;
    vs_dly_d   = vs_q;
    href_dly_d = href_q;
  end

  // pin capture and edge-detect delay flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q       <= 1'b0;
      vs_dly_q   <= 1'b0;
      href_q     <= 1'b0;
      href_dly_q <= 1'b0;
      d_q        <= 8'h00;
    end else begin
      vs_q       <= vs_d;
      vs_dly_q   <= vs_dly_d;
      href_q     <= href_d;
      href_dly_q <= href_dly_d;
      d_q        <= d_d;
    end
  end

  assign vs_act    = vs_q & ~vs_dly_q;
  assign vs_start  = ~vs_q & vs_dly_q;
  assign href_r    = href_q;
  assign href_fall = ~href_q & href_dly_q;
  assign d_r       = d_q;

endmodule

// File: rtl/cmos_capture_16b.sv
// DVP capture: skips start-up frames, then packs byte pairs into RGB565 for one
// IMG_ROW x IMG_COL window. Define CMOS_CAP_CONTINUOUS_EN to capture every frame.
module cmos_capture_16b
  import cmos_cap_pkg::*;
#(
  parameter int IMG_ROW     = IMG_ROW_DEF,
  parameter int IMG_COL     = IMG_COL_DEF,
  parameter int SKIP_FRAMES = 10,
  parameter bit VSYNC_POL   = 1'b1
) (
  input  logic        cmos_pclk,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_d,
  output logic [15:0] data_16b,
  output logic        data_16b_en,
  output logic        cmos_data_valid,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int LW = cnt_width(IMG_ROW);
  localparam int PW = cnt_width(IMG_COL);
  localparam int SW = cnt_width(SKIP_FRAMES);
  localparam logic [LW-1:0] ROW_MAX   = LW'(IMG_ROW);
  localparam logic [PW-1:0] COL_MAX   = PW'(IMG_COL);
  localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_FRAMES);
  localparam logic [LW-1:0] LINE_ONE  = LW'(1'b1);
  localparam logic [PW-1:0] PIX_ONE   = PW'(1'b1);
  localparam logic [SW-1:0] SKIP_ONE  = SW'(1'b1);

  logic       vs_start_s, vs_act_s, href_r_s, href_fall_s;
  logic [7:0] d_r_s;

  cmos_sync_edge #(.VSYNC_POL(VSYNC_POL)) u_sync (
    .clk       (cmos_pclk),
    .rst       (rst),
    .vsync_i   (cmos_vsync),
    .href_i    (cmos_href),
    .d_i       (cmos_d),
    .vs_start  (vs_start_s),
    .vs_act    (vs_act_s),
    .href_r    (href_r_s),
    .href_fall (href_fall_s),
    .d_r       (d_r_s)
  );

  cap_state_e    state_d, state_q;
  logic [SW-1:0] skip_cnt_d, skip_cnt_q;
  logic [LW-1:0] line_cnt_d, line_cnt_q;
  logic [PW-1:0] pixel_cnt_d, pixel_cnt_q;
  logic          phase_d, phase_q;
  logic [7:0]    hi_byte_d, hi_byte_q;
  logic [15:0]   data_d, data_q;
  logic          en_d, en_q, valid_d, valid_q, done_d, done_q, err_d, err_q;

  // frame sequencing, byte packing and line/frame accounting
  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    line_cnt_d  = line_cnt_q;
    pixel_cnt_d = pixel_cnt_q;
    phase_d     = phase_q;
    hi_byte_d   = hi_byte_q;
    data_d      = data_q;
    en_d        = 1'b0;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_SKIP: begin
        valid_d = 1'b0;
        if (SKIP_FRAMES == 0) begin
          state_d = ST_WAIT_FRAME;
        end else if (vs_act_s) begin
          skip_cnt_d = skip_cnt_q + SKIP_ONE;
          if (skip_cnt_q + SKIP_ONE == SKIP_LAST) state_d = ST_WAIT_FRAME;
          else state_d = ST_SKIP;
        end else begin
          state_d = ST_SKIP;
        end
      end
      ST_WAIT_FRAME: begin
        if (vs_start_s) begin
          state_d     = ST_CAPTURE;
          valid_d     = 1'b1;
          line_cnt_d  = {LW{1'b0}};
          pixel_cnt_d = {PW{1'b0}};
          phase_d     = 1'b0;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        // Line end takes priority over a coincident vsync so a completing line still finishes the frame.
        if (href_fall_s) begin
          line_cnt_d  = line_cnt_q + LINE_ONE;
          pixel_cnt_d = {PW{1'b0}};
          phase_d     = 1'b0;
          if (phase_q || (pixel_cnt_q < COL_MAX)) err_d = 1'b1;
          else err_d = err_q;
          if (line_cnt_q + LINE_ONE == ROW_MAX) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (vs_act_s) begin
            state_d = ST_WAIT_FRAME;
            valid_d = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else if (vs_act_s) begin
          state_d = ST_WAIT_FRAME;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end else if (href_r_s) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_byte_d = d_r_s;
          end else if (pixel_cnt_q < COL_MAX) begin
            data_d      = pack_pixel(hi_byte_q, d_r_s);
            en_d        = 1'b1;
            pixel_cnt_d = pixel_cnt_q + PIX_ONE;
          end else begin
            pixel_cnt_d = pixel_cnt_q;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
`ifdef CMOS_CAP_CONTINUOUS_EN
        state_d = ST_WAIT_FRAME;
`else
        state_d = ST_DONE;
`endif
      end
      default: begin
        state_d = ST_SKIP;
        valid_d = 1'b0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SKIP;
      skip_cnt_q  <= {SW{1'b0}};
      line_cnt_q  <= {LW{1'b0}};
      pixel_cnt_q <= {PW{1'b0}};
      phase_q     <= 1'b0;
      hi_byte_q   <= 8'h00;
      data_q      <= 16'h0000;
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      line_cnt_q  <= line_cnt_d;
      pixel_cnt_q <= pixel_cnt_d;
      phase_q     <= phase_d;
      hi_byte_q   <= hi_byte_d;
      data_q      <= data_d;
      en_q        <= en_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign data_16b        = data_q;
  assign data_16b_en     = en_q;
  assign cmos_data_valid = valid_q;
  assign frame_done      = done_q;
  assign frame_err       = err_q;

endmodule

// File: tb/tb_cmos_capture_16b.sv
// Directed bench for cmos_capture_16b with a frame-level reference model that
// predicts every output on every cycle, plus hand-computed anchor checks.
module tb_cmos_capture_16b;

  localparam int ROW  = 4;
  localparam int COL  = 8;
  localparam int SKIP = 2;

  logic        cmos_pclk = 1'b0;
  logic        rst = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_d = 8'h00;
  logic [15:0] data_16b;
  logic        data_16b_en, cmos_data_valid, frame_done, frame_err;

  cmos_capture_16b #(.IMG_ROW(ROW), .IMG_COL(COL), .SKIP_FRAMES(SKIP), .VSYNC_POL(1'b1)) dut (
    .cmos_pclk       (cmos_pclk),
    .rst             (rst),
    .cmos_vsync      (cmos_vsync),
    .cmos_href       (cmos_href),
    .cmos_d          (cmos_d),
    .data_16b        (data_16b),
    .data_16b_en     (data_16b_en),
    .cmos_data_valid (cmos_data_valid),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  initial forever #5 cmos_pclk = ~cmos_pclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt, done_cnt, first_en, last_en, rise_cyc, fall_cyc;
  int vs_rise_drv, vs_fall_drv, t2_drv;
  logic prev_valid = 1'b0;

  typedef struct packed {
    logic        v;
    logic        en;
    logic        done;
    logic        err;
    logic [15:0] data;
  } exp_t;
  exp_t exp_tab[8];
  bit   exp_set[8];

  // Reference model: frame-level view of the sensor stream.
  typedef enum int {M_SKIP, M_WAIT, M_CAP, M_DONE} mmode_e;
  mmode_e      m_mode;
  int          m_vs_seen, m_lines;
  logic [7:0]  m_line[$];
  logic [15:0] m_data;
  logic        m_err, m_prev_vs, m_prev_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SKIP; m_vs_seen = 0; m_lines = 0; m_line.delete();
    m_data = 16'h0000; m_err = 1'b0; m_prev_vs = 1'b0; m_prev_h = 1'b0;
  endtask

  // Pins driven now are seen by the DUT at the next edge; results show one edge later.
  task automatic model_step(input logic vs, input logic hr, input logic [7:0] d);
    logic act, start, hfall;
    int   n;
    exp_t e;
    act   = vs && !m_prev_vs;
    start = !vs && m_prev_vs;
    hfall = !hr && m_prev_h;
    e.en = 1'b0; e.done = 1'b0;
    case (m_mode)
      M_SKIP: if (act) begin
        m_vs_seen++;
        if (m_vs_seen >= SKIP) m_mode = M_WAIT;
      end
      M_WAIT: if (start) begin
        m_mode = M_CAP; m_lines = 0; m_line.delete();
      end
      M_CAP: begin
        if (hfall) begin
          n = m_line.size();
          if ((n % 2) != 0 || (n / 2) < COL) m_err = 1'b1;
          m_lines++;
          m_line.delete();
          if (m_lines == ROW) begin
            e.done = 1'b1; m_mode = M_DONE;
          end else if (act) begin
            m_err = 1'b1; m_mode = M_WAIT;
          end
        end else if (act) begin
          m_err = 1'b1; m_mode = M_WAIT;
        end else if (hr) begin
          m_line.push_back(d);
          n = m_line.size();
          if ((n % 2) == 0 && (n / 2) <= COL) begin
            e.en = 1'b1;
            m_data = {m_line[n-2], m_line[n-1]};
          end
        end
      end
      M_DONE: begin
`ifdef CMOS_CAP_CONTINUOUS_EN
        m_mode = M_WAIT;
`endif
      end
      default: m_mode = M_SKIP;
    endcase
    e.v = (m_mode == M_CAP);
    e.err = m_err;
    e.data = m_data;
    exp_tab[(cyc + 2) % 8] = e;
    exp_set[(cyc + 2) % 8] = 1'b1;
    m_prev_vs = vs;
    m_prev_h  = hr;
  endtask

  initial forever begin
    @(posedge cmos_pclk);
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model plus event bookkeeping.
  initial forever begin
    @(negedge cmos_pclk);
    if (data_16b_en === 1'b1) begin
      en_cnt++;
      last_en = cyc;
      if (first_en < 0) first_en = cyc;
    end
    if (frame_done === 1'b1) done_cnt++;
    if (cmos_data_valid === 1'b1 && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    if (cmos_data_valid === 1'b0 && prev_valid && fall_cyc < 0) fall_cyc = cyc;
    prev_valid = (cmos_data_valid === 1'b1);
    if (exp_set[cyc % 8]) begin
      exp_set[cyc % 8] = 1'b0;
      check("cycle_outputs", {12'h000, cmos_data_valid, data_16b_en, frame_done, frame_err, data_16b},
            {12'h000, exp_tab[cyc % 8]});
    end
  end

  task automatic clr();
    en_cnt = 0; done_cnt = 0; first_en = -1; last_en = -1; rise_cyc = -1; fall_cyc = -1;
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge cmos_pclk); #1;
    cmos_vsync = vs; cmos_href = hr; cmos_d = d;
    model_step(vs, hr, d);
  endtask

  task automatic do_reset();
    @(posedge cmos_pclk); #1;
    rst = 1'b1; cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_d = 8'h00;
    for (int i = 0; i < 8; i++) exp_set[i] = 1'b0;
    #1;
    check("reset_outputs", {12'h000, cmos_data_valid, data_16b_en, frame_done, frame_err, data_16b}, 32'h0);
    model_reset();
    repeat (2) @(posedge cmos_pclk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vpulse();
    drive(1'b1, 1'b0, 8'h00);
    vs_rise_drv = cyc;
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    vs_fall_drv = cyc;
    idle(5);
  endtask

  task automatic line(input int n, input bit pat, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, pat ? (((i % 2) == 1) ? 8'h34 : 8'h12) : base + 8'(i));
      if (i == 1 && t2_drv < 0) t2_drv = cyc;
    end
    idle(4);
  endtask

  task automatic frame(input bit pat, input logic [7:0] base);
    for (int l = 0; l < ROW; l++) line(16, pat, base + 8'(l * 16));
  endtask

  initial begin
    t2_drv = -1;
    clr();
    // A: two skipped frames, then one captured 0x12/0x34 frame
    do_reset(); clr();
    frame(1'b0, 8'h20); vpulse(); frame(1'b0, 8'h40); vpulse();
    t2_drv = -1;
    frame(1'b1, 8'h00); idle(10);
    check("a_strobes", en_cnt, 32);
    check("a_done", done_cnt, 1);
    check("a_data", {16'h0, data_16b}, 32'h1234);
    check("a_err", {31'h0, frame_err}, 32'h0);
    check("a_valid_fall", fall_cyc, last_en + 1);
    check("a_valid_rise", rise_cyc, vs_fall_drv + 2);
    check("a_en_latency", first_en, t2_drv + 2);

    // B: long line, odd line, abort, then a clean retry frame
    do_reset(); clr();
    vpulse(); vpulse();
    line(18, 1'b0, 8'h80);
    check("b_long_strobes", en_cnt, 8);
    check("b_long_err", {31'h0, frame_err}, 32'h0);
    line(15, 1'b0, 8'hA0);
    check("b_odd_strobes", en_cnt, 15);
    check("b_odd_err", {31'h0, frame_err}, 32'h1);
    fall_cyc = -1;
    vpulse();
    check("b_abort_fall", fall_cyc, vs_rise_drv + 2);
    check("b_abort_done", done_cnt, 0);
    check("b_abort_err", {31'h0, frame_err}, 32'h1);
    en_cnt = 0;
    frame(1'b0, 8'h60); idle(6);
    check("b_retry_strobes", en_cnt, 32);
    check("b_retry_done", done_cnt, 1);

    // C: reset mid-capture, skip restarts, then three back-to-back frames
    do_reset(); clr();
    vpulse(); vpulse();
    line(16, 1'b0, 8'h10); line(16, 1'b0, 8'h30);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'hC0 + 8'(i));
    check("c_valid_pre_rst", {31'h0, cmos_data_valid}, 32'h1);
    do_reset(); clr();
    frame(1'b0, 8'h05); vpulse(); frame(1'b0, 8'h07); vpulse();
    frame(1'b0, 8'h09); idle(4);
    check("c_strobes_first", en_cnt, 32);
    check("c_done_first", done_cnt, 1);
    vpulse(); frame(1'b0, 8'h0B); vpulse(); frame(1'b0, 8'h0D); idle(6);
`ifdef CMOS_CAP_CONTINUOUS_EN
    check("c_strobes_total", en_cnt, 96);
    check("c_done_total", done_cnt, 3);
`else
    check("c_strobes_total", en_cnt, 32);
    check("c_done_total", done_cnt, 1);
    check("c_valid_idle", {31'h0, cmos_data_valid}, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
